flb_lock_ctrl: RTL and testbench

Frequency-lock loop controller for the DPLL FLB: compares per-window DCO cycle counts against a target and produces the binary coarse band code (`s_band`) and fine matrix code (`s_mtrx`) consumed directly by the thermometer decoder stage downstream. It runs a binary-search coarse acquisition followed by linear fine tracking with lock detection. All outputs are registered.

---
 rtl/flb_lock_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_flb_lock_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flb_lock_ctrl.sv
// -----------------------------------------------------------------------------
// flb_lock_ctrl -- frequency-lock loop controller for the DPLL FLB.
//
// Compares each per-window DCO cycle count against a target and drives the
// binary coarse band code and fine matrix code into the downstream
// thermometer decoder. Acquisition is an 8-step binary search on the band
// code, followed by +/-1 tracking on the matrix code with lock detection.
// All outputs are registered.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         level enable; low returns to IDLE, high in IDLE starts acquisition
//   tgt_cnt    target DCO count per window (unsigned, CW bits)
//   tol        accepted |error| window for fine lock (unsigned)
//   cnt_valid  single-cycle strobe qualifying cnt_val
//   cnt_val    measured DCO count (unsigned, CW bits)
//   s_band     coarse band code
//   s_mtrx     fine matrix code
//   busy       high while acquiring, tracking or locked
//   lock       frequency lock indicator
//   sat        sticky: a fine step past 0 or 255 was suppressed
// -----------------------------------------------------------------------------
module flb_lock_ctrl #(
    parameter int         CW         = 16,
    parameter int         SETTLE     = 2,
    parameter int         LOCK_CNT   = 4,
    parameter int         UNLOCK_CNT = 2,
    parameter logic [7:0] MTRX_INIT  = 8'h80
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [CW-1:0] tgt_cnt,
    input  logic [7:0]    tol,
    input  logic          cnt_valid,
    input  logic [CW-1:0] cnt_val,
    output logic [7:0]    s_band,
    output logic [7:0]    s_mtrx,
    output logic          busy,
    output logic          lock,
    output logic          sat
);

    // Counter widths sized so each counter can hold its terminal value.
    localparam int SW = (SETTLE     > 0) ? $clog2(SETTLE + 1)     : 1;
    localparam int LW = (LOCK_CNT   > 0) ? $clog2(LOCK_CNT + 1)   : 1;
    localparam int UW = (UNLOCK_CNT > 0) ? $clog2(UNLOCK_CNT + 1) : 1;

    localparam logic [SW-1:0] SETTLE_V = SW'(SETTLE);
    localparam logic [LW-1:0] LOCK_V   = LW'(LOCK_CNT);
    localparam logic [UW-1:0] UNLOCK_V = UW'(UNLOCK_CNT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COARSE,
        S_FINE,
        S_LOCK
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    k_q, k_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [LW-1:0] lcnt_q, lcnt_d, lcnt_inc;
    logic [UW-1:0] ucnt_q, ucnt_d, ucnt_inc;
    logic [7:0]    band_d, mtrx_d;
    logic          busy_d, lock_d, sat_d;
    logic          start;

    // Error evaluation: one extra bit makes the unsigned subtraction a
    // two's-complement signed error; the MSB is the "too slow" flag.
    logic [CW:0]   diff, mag;
    logic          too_slow, in_win;

    always_comb begin
        diff     = {1'b0, cnt_val} - {1'b0, tgt_cnt};
        too_slow = diff[CW];
        mag      = too_slow ? -diff : diff;
        in_win   = (mag <= {{(CW-7){1'b0}}, tol});
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        settle_d = settle_q;
        lcnt_d   = lcnt_q;
        ucnt_d   = ucnt_q;
        band_d   = s_band;
        mtrx_d   = s_mtrx;
        lock_d   = lock;
        sat_d    = sat;
        start    = 1'b0;
        lcnt_inc = lcnt_q + LW'(1);
        ucnt_inc = ucnt_q + UW'(1);

        if (!en) begin
            // Codes are left where they are; only status drops.
            state_d = S_IDLE;
            lock_d  = 1'b0;
        end else if (state_q == S_IDLE) begin
            band_d  = 8'h80;
            mtrx_d  = MTRX_INIT;
            k_d     = 3'd7;
            sat_d   = 1'b0;
            lcnt_d  = '0;
            ucnt_d  = '0;
            start   = 1'b1;
            state_d = S_COARSE;
        end else if (cnt_valid) begin
            if (settle_q != '0) begin
                // Measurement still reflects the previous code: discard.
                settle_d = settle_q - SW'(1);
            end else begin
                case (state_q)
                    S_COARSE: begin
                        // Binary search: bit k stays only if still too slow.
                        if (!too_slow) band_d[k_q] = 1'b0;
                        if (k_q != 3'd0) begin
                            band_d[k_q - 3'd1] = 1'b1;
                            k_d                = k_q - 3'd1;
                        end else begin
                            state_d = S_FINE;
                            lcnt_d  = '0;
                        end
                    end
                    default: begin
                        // FINE and LOCK share the same +/-1 stepping rule.
                        if (!in_win) begin
                            if (too_slow) begin
                                if (s_mtrx == 8'hFF) sat_d  = 1'b1;
                                else                 mtrx_d = s_mtrx + 8'd1;
                            end else begin
                                if (s_mtrx == 8'h00) sat_d  = 1'b1;
                                else                 mtrx_d = s_mtrx - 8'd1;
                            end
                        end
                        if (state_q == S_FINE) begin
                            if (!in_win) begin
                                lcnt_d = '0;
                            end else begin
                                lcnt_d = lcnt_inc;
                                if (lcnt_inc == LOCK_V) begin
                                    lock_d  = 1'b1;
                                    ucnt_d  = '0;
                                    state_d = S_LOCK;
                                end
                            end
                        end else begin
                            if (in_win) begin
                                ucnt_d = '0;
                            end else if (ucnt_inc == UNLOCK_V) begin
                                lock_d  = 1'b0;
                                lcnt_d  = '0;
                                ucnt_d  = '0;
                                state_d = S_FINE;
                            end else begin
                                ucnt_d = ucnt_inc;
                            end
                        end
                    end
                endcase
            end
        end

        // Any code movement (and every acquisition start) opens a fresh
        // settle window so stale counts never steer the loop.
        if (start || (band_d != s_band) || (mtrx_d != s_mtrx))
            settle_d = SETTLE_V;

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            k_q      <= 3'd0;
            settle_q <= '0;
            lcnt_q   <= '0;
            ucnt_q   <= '0;
            s_band   <= 8'h80;
            s_mtrx   <= MTRX_INIT;
            busy     <= 1'b0;
            lock     <= 1'b0;
            sat      <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            settle_q <= settle_d;
            lcnt_q   <= lcnt_d;
            ucnt_q   <= ucnt_d;
            s_band   <= band_d;
            s_mtrx   <= mtrx_d;
            busy     <= busy_d;
            lock     <= lock_d;
            sat      <= sat_d;
        end
    end

endmodule

// File: tb/tb_flb_lock_ctrl.sv
module tb_flb_lock_ctrl;

    localparam int SETTLE     = 2;
    localparam int LOCK_CNT   = 4;
    localparam int UNLOCK_CNT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0, cnt_valid = 1'b0;
    logic [15:0] tgt_cnt = 16'd400, cnt_val = 16'd0;
    logic [7:0]  tol = 8'd1;
    logic [7:0]  s_band, s_mtrx;
    logic        busy, lock, sat;

    // Second instance for the saturation corner (fine code starts at 0xFE).
    logic        en_s = 1'b0, cv_s = 1'b0;
    logic [15:0] val_s = 16'd0;
    logic [7:0]  band_s, mtrx_s;
    logic        busy_s, lock_s, sat_s;

    always #5 clk = ~clk;

    flb_lock_ctrl dut (
        .clk(clk), .rst_n(rst_n), .en(en), .tgt_cnt(tgt_cnt), .tol(tol),
        .cnt_valid(cnt_valid), .cnt_val(cnt_val),
        .s_band(s_band), .s_mtrx(s_mtrx), .busy(busy), .lock(lock), .sat(sat)
    );

    flb_lock_ctrl #(.MTRX_INIT(8'hFE)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en_s), .tgt_cnt(tgt_cnt), .tol(tol),
        .cnt_valid(cv_s), .cnt_val(val_s),
        .s_band(band_s), .s_mtrx(mtrx_s), .busy(busy_s), .lock(lock_s), .sat(sat_s)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model -----------------
    // Phase: 0 idle, 1 coarse search, 2 fine tracking, 3 locked.
    int m_phase, m_band, m_mtrx, m_bit, m_settle, m_inwin_run, m_miss_run;
    bit m_lock, m_sat;

    task automatic model_reset();
        m_phase = 0; m_band = 128; m_mtrx = 128; m_bit = 0; m_settle = 0;
        m_inwin_run = 0; m_miss_run = 0; m_lock = 0; m_sat = 0;
    endtask

    task automatic model_step();
        int d, want, ob, om;
        bit inwin;
        if (!rst_n) begin model_reset(); return; end
        if (!en) begin
            m_phase = 0; m_lock = 0;
        end else if (m_phase == 0) begin
            m_band = 128; m_mtrx = 128; m_bit = 7; m_sat = 0;
            m_settle = SETTLE; m_inwin_run = 0; m_miss_run = 0; m_phase = 1;
        end else if (cnt_valid) begin
            if (m_settle > 0) m_settle--;
            else begin
                d  = int'(cnt_val) - int'(tgt_cnt);
                ob = m_band; om = m_mtrx;
                inwin = (d <= int'(tol)) && (d >= -int'(tol));
                if (m_phase == 1) begin
                    if (d >= 0) m_band -= (1 << m_bit);
                    if (m_bit > 0) begin m_bit--; m_band += (1 << m_bit); end
                    else begin m_phase = 2; m_inwin_run = 0; end
                end else begin
                    want = inwin ? m_mtrx : (d < 0 ? m_mtrx + 1 : m_mtrx - 1);
                    if (want < 0 || want > 255) m_sat = 1; else m_mtrx = want;
                    if (m_phase == 2) begin
                        if (inwin) begin
                            m_inwin_run++;
                            if (m_inwin_run == LOCK_CNT) begin m_lock = 1; m_miss_run = 0; m_phase = 3; end
                        end else m_inwin_run = 0;
                    end else begin
                        if (inwin) m_miss_run = 0;
                        else begin
                            m_miss_run++;
                            if (m_miss_run == UNLOCK_CNT) begin
                                m_lock = 0; m_inwin_run = 0; m_miss_run = 0; m_phase = 2;
                            end
                        end
                    end
                end
                if (ob != m_band || om != m_mtrx) m_settle = SETTLE;
            end
        end
    endtask

    // One clock: inputs were set before the call; outputs sampled at negedge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic strobe(input int v);
        cnt_valid = 1'b1; cnt_val = 16'(v);
        tick();
        cnt_valid = 1'b0;
    endtask

    task automatic strobe_s(input int v);
        cv_s = 1'b1; val_s = 16'(v);
        tick();
        cv_s = 1'b0;
    endtask

    typedef struct {
        bit         en;
        bit         v;
        int         val;
        logic [7:0] band;
        logic [7:0] mtrx;
        bit         busy;
        bit         lock;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev, decs, since, uv[8];
        int nz;
        model_reset();

        tbl[0]  = '{0, 0,   0, 8'h80, 8'h80, 0, 0};
        tbl[1]  = '{1, 0,   0, 8'h80, 8'h80, 1, 0};  // acquisition start
        tbl[2]  = '{1, 1, 512, 8'h80, 8'h80, 1, 0};  // settle discard
        tbl[3]  = '{1, 1, 512, 8'h80, 8'h80, 1, 0};  // settle discard
        tbl[4]  = '{1, 0,   0, 8'h80, 8'h80, 1, 0};
        tbl[5]  = '{1, 1, 512, 8'h40, 8'h80, 1, 0};  // too fast: clear b7
        tbl[6]  = '{1, 1, 256, 8'h40, 8'h80, 1, 0};
        tbl[7]  = '{1, 1, 256, 8'h40, 8'h80, 1, 0};
        tbl[8]  = '{1, 1, 256, 8'h60, 8'h80, 1, 0};  // too slow: keep b6
        tbl[9]  = '{0, 1,   0, 8'h60, 8'h80, 0, 0};  // en drop wins over strobe
        tbl[10] = '{0, 0,   0, 8'h60, 8'h80, 0, 0};
        tbl[11] = '{1, 0,   0, 8'h80, 8'h80, 1, 0};  // restart

        @(negedge clk);
        chk("rst_band", s_band, 8'h80); chk("rst_mtrx", s_mtrx, 8'h80);
        chk("rst_busy", busy, 0); chk("rst_lock", lock, 0); chk("rst_sat", sat, 0);
        rst_n = 1'b1;

        // ---------------- table vectors ----------------
        for (int i = 0; i < 12; i++) begin
            en = tbl[i].en; cnt_valid = tbl[i].v; cnt_val = 16'(tbl[i].val);
            tick();
            chk($sformatf("tbl%0d_band", i), s_band, tbl[i].band);
            chk($sformatf("tbl%0d_mtrx", i), s_mtrx, tbl[i].mtrx);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("tbl%0d_lock", i), lock, tbl[i].lock);
        end
        cnt_valid = 1'b0;

        // ---------------- enable drop at k=4 ----------------
        for (int i = 0; i < 9; i++) strobe(4 * int'(s_band));
        chk("k4_band", s_band, 8'h70);
        en = 1'b0; tick();
        chk("drop_busy", busy, 0); chk("drop_band", s_band, 8'h70); chk("drop_mtrx", s_mtrx, 8'h80);
        tick();
        chk("drop_hold", s_band, 8'h70);
        en = 1'b1; tick();
        chk("reen_band", s_band, 8'h80); chk("reen_busy", busy, 1);
        for (int i = 0; i < 3; i++) strobe(4 * int'(s_band));
        chk("reen_k7", s_band, 8'h40);

        // ---------------- full coarse search ----------------
        en = 1'b0; tick(); en = 1'b1; tick();
        tgt_cnt = 16'd400; tol = 8'd1;
        for (int i = 1; i <= 24; i++) begin
            strobe(4 * int'(s_band));
            if (i == 18) chk("coarse_6acc", s_band, 8'h62);
        end
        chk("coarse_band", s_band, 8'h63); chk("coarse_mtrx", s_mtrx, 8'h80);

        // ---------------- fine tracking and lock ----------------
        decs = 0; since = 0;
        for (int i = 0; i < 300 && !lock; i++) begin
            prev = int'(s_mtrx);
            strobe(4 * int'(s_band) + int'(s_mtrx >> 4));
            if (int'(s_mtrx) != prev) begin decs++; since = 0; end else since++;
        end
        chk("fine_decs", decs, 33); chk("fine_mtrx", s_mtrx, 8'h5F);
        chk("fine_lock", lock, 1); chk("lock_strobes", since, 2 + LOCK_CNT);
        chk("fine_band", s_band, 8'h63);

        // ---------------- unlock ----------------
        uv = '{410, 400, 400, 400, 410, 400, 400, 410};
        for (int i = 0; i < 8; i++) begin
            strobe(uv[i]);
            if (i == 0) begin chk("ul0_lock", lock, 1); chk("ul0_mtrx", s_mtrx, 8'h5E); end
            if (i == 4) begin chk("ul4_lock", lock, 1); chk("ul4_mtrx", s_mtrx, 8'h5D); end
            if (i == 6) chk("ul6_lock", lock, 1);
            if (i == 7) begin chk("ul7_lock", lock, 0); chk("ul7_mtrx", s_mtrx, 8'h5C); end
        end

        // ---------------- async reset mid-FINE ----------------
        en = 1'b0; rst_n = 1'b0;
        #1;
        chk("arst_band", s_band, 8'h80); chk("arst_mtrx", s_mtrx, 8'h80);
        chk("arst_lock", lock, 0); chk("arst_busy", busy, 0); chk("arst_sat", sat, 0);
        model_reset();
        tick(); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("idle_band", s_band, 8'h80); chk("idle_mtrx", s_mtrx, 8'h80); chk("idle_busy", busy, 0);

        // ---------------- saturation ----------------
        en_s = 1'b1; tick();
        chk("sat_init", mtrx_s, 8'hFE);
        for (int i = 0; i < 24; i++) strobe_s(350);
        chk("sat_band", band_s, 8'hFF); chk("sat_pre", mtrx_s, 8'hFE);
        strobe_s(350);
        chk("sat_ff", mtrx_s, 8'hFF); chk("sat_clr", sat_s, 0);
        strobe_s(350); strobe_s(350); strobe_s(350);
        chk("sat_hold", mtrx_s, 8'hFF); chk("sat_set", sat_s, 1);
        en_s = 1'b0; tick(); en_s = 1'b1; tick();
        chk("sat_restart", sat_s, 0); chk("sat_remtrx", mtrx_s, 8'hFE);
        en_s = 1'b0;

        // ---------------- randomized vs model ----------------
        rst_n = 1'b0; model_reset(); tick(); rst_n = 1'b1;
        tgt_cnt = 16'(450); tol = 8'd2;
        for (int n = 0; n < 3000; n++) begin
            if (!en) begin
                tgt_cnt = 16'($urandom_range(200, 900));
                tol     = 8'($urandom_range(0, 6));
                en      = 1'b1;
            end else begin
                en = ($urandom_range(0, 199) != 0);
            end
            cnt_valid = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) nz = int'($urandom_range(0, 80)) - 40;
            else                            nz = int'($urandom_range(0, 6)) - 3;
            nz = 4 * m_band + (m_mtrx >> 4) + nz;
            cnt_val = 16'((nz < 0) ? 0 : nz);
            tick();
            chk("rnd_band", s_band, 32'(m_band));
            chk("rnd_mtrx", s_mtrx, 32'(m_mtrx));
            chk("rnd_busy", busy, 32'(m_phase != 0));
            chk("rnd_lock", lock, 32'(m_lock));
            chk("rnd_sat", sat, 32'(m_sat));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
